// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the memory arbiter slice.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_e;

    typedef enum logic {
        ST_RR     = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-input round-robin picker: on a tie the port not granted most recently wins.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic  req_core,
    input  logic  req_dbg,
    input  port_e last,
    output logic  gnt_core_c,
    output logic  gnt_dbg_c
);

    always_comb begin
        gnt_core_c = 1'b0;
        gnt_dbg_c  = 1'b0;
        if (req_core && req_dbg) begin
            gnt_core_c = (last == PORT_DBG);
            gnt_dbg_c  = (last == PORT_CORE);
        end else begin
            gnt_core_c = req_core;
            gnt_dbg_c  = req_dbg;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Core/debug arbiter in front of a single-port synchronous memory, with a debug lock
// and one-cycle read-return routing.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = ADDR_W,
    parameter int unsigned DW = DATA_W
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    state_e state;
    port_e  last_gnt;
    logic   rd_pend;
    port_e  rd_owner;

    logic   lock_hold;
    logic   core_elig;
    logic   pick_core;
    logic   pick_dbg;

    // Lock only holds while d_lock stays high; the release cycle already arbitrates RR.
    assign lock_hold = (state == ST_LOCKED) && d_lock;
    assign core_elig = c_req && !lock_hold;

    rr_pick2 u_pick (
        .req_core   (core_elig),
        .req_dbg    (d_req),
        .last       (last_gnt),
        .gnt_core_c (pick_core),
        .gnt_dbg_c  (pick_dbg)
    );

    assign c_gnt   = pick_core && !reset;
    assign d_gnt   = pick_dbg && !reset;
    assign c_stall = c_req && !c_gnt && !reset;

    // Memory command mux driven by the winner in the grant cycle.
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = c_addr;
        m_wdata = c_wdata;
        if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (c_gnt) begin
            m_en    = 1'b1;
            m_we    = c_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RR;
            last_gnt <= PORT_DBG;
            rd_pend  <= 1'b0;
            rd_owner <= PORT_CORE;
        end else begin
            case (state)
                ST_RR:     if (d_gnt && d_lock) state <= ST_LOCKED;
                ST_LOCKED: if (!d_lock)         state <= ST_RR;
                default:                        state <= ST_RR;
            endcase

            if (c_gnt)      last_gnt <= PORT_CORE;
            else if (d_gnt) last_gnt <= PORT_DBG;

            rd_pend <= (c_gnt && !c_we) || (d_gnt && !d_we);
            if (c_gnt || d_gnt) rd_owner <= d_gnt ? PORT_DBG : PORT_CORE;
        end
    end

    assign c_rvalid = rd_pend && (rd_owner == PORT_CORE);
    assign d_rvalid = rd_pend && (rd_owner == PORT_DBG);
    assign c_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
